pe_mac_stream: RTL and testbench
================================

Name: pe_mac_stream

Overview:
Next-generation systolic processing element with a valid-qualified data path. Operands are forwarded to the right and down neighbours with one cycle of latency. Each PE accumulates a runtime-programmable number of signed products. It then hands the full-resolution result to a holding register that drains through a valid/ready handshake toward the output FIFO. This lets the array compute back-to-back matrices of varying inner dimension without self-blocking or losing results.

Parameters:
I_BITS, 8, signed operand width, format S(I_BITS, I_BITS-1)
MAX_LEN, 16, maximum accumulation length (inner dimension) supported
LEN_BITS, $clog2(MAX_LEN+1), width of the length input
O_BITS, 2*I_BITS+$clog2(MAX_LEN), full-resolution accumulator/result width

Ports:
i_clock  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous soft clear (accumulator, counter, result slot, overrun)
i_valid  in  1  i_a/i_b beat valid
i_a  in  I_BITS  signed operand from left neighbour
i_b  in  I_BITS  signed operand from upper neighbour
i_len  in  LEN_BITS  products per result; sampled on the first beat of each vector
o_a  out  I_BITS  registered i_a to right neighbour
o_b  out  I_BITS  registered i_b to lower neighbour
o_valid  out  1  registered i_valid to neighbours
o_c  out  O_BITS  held result
o_c_valid  out  1  result slot full
i_c_ready  in  1  consumer accepts o_c
o_busy  out  1  vector accumulation in progress (counter != 0)
o_overrun  out  1  sticky: a result was overwritten before being consumed
o_q  out  I_BITS  quantised result (see Optional Feature)

Behaviour:
- Reset (i_reset_n=0, async): every output and internal register is 0, and the FSM is IDLE.
- Forward path:
  - o_a/o_b/o_valid <= i_a/i_b/i_valid every cycle, regardless of state.
  - Latency is 1 cycle, with no stall.
  - i_clear does not affect the forward path.
- Product: prod = i_a*i_b, signed, 2*I_BITS wide, sign-extended to O_BITS.
- Accumulator FSM:
  - IDLE (cnt=0):
    - On i_valid: latch len_q = (i_len==0 ? 1 : min(i_len, MAX_LEN)), set acc <= prod, set cnt <= 1.
    - If len_q==1, emit immediately and stay IDLE.
    - Otherwise go to RUN.
  - RUN:
    - On i_valid: acc <= acc+prod and cnt <= cnt+1.
    - When cnt+1 == len_q, emit acc+prod, then set cnt <= 0 and go to IDLE.
    - Beats with i_valid=0 hold all state (bubbles are allowed).
  - Emit: result <= final sum; the accumulator is free for the next vector's first beat in the following cycle, so back-to-back vectors have no gap.
- Result slot:
  - On emit: o_c <= sum and o_c_valid <= 1.
  - On o_c_valid & i_c_ready with no emit: o_c_valid <= 0; o_c holds its value.
  - Emit and consume in the same cycle: the new value is loaded and o_c_valid stays 1.
  - Emit while o_c_valid=1 and i_c_ready=0: the new value overwrites the old one and o_overrun <= 1 (sticky).
- Arithmetic: full resolution, no overflow possible within MAX_LEN terms (O_BITS sized for it). Sums of more terms are impossible because len is clamped.
- o_busy = (state==RUN).
- i_clear:
  - Same cycle: acc, cnt, len_q, o_c, o_c_valid, o_overrun and o_q all go to 0, and the FSM goes to IDLE.
  - An i_valid beat in the same cycle is discarded.
  - Takes priority over emit and consume.
- Async reset mid-vector aborts the vector; no partial result is ever emitted.

Optional Feature:
PE_QOUT_EN
- Defined: o_q is the quantised o_c, updated in the same cycle as o_c.
  - Shift right by I_BITS-1 with round-half-up (add 2^(I_BITS-2) before shifting).
  - Saturate to [-2^(I_BITS-1), 2^(I_BITS-1)-1].
- Undefined: o_q is tied to 0 and the rounding/saturation logic is not synthesised.

Decomposition:
- Package pe_pkg holds:
  - state encoding constants IDLE=1'b0, RUN=1'b1;
  - the O_BITS/LEN_BITS derivation function;
  - the default I_BITS and MAX_LEN.
- One sub-module, pe_quant_sat: combinational round-and-saturate.
  - Instantiated only under PE_QOUT_EN.
  - Reused later by the array output stage.

Test Plan:
- Reset: assert i_reset_n=0 asynchronously mid-RUN -> all outputs 0 immediately; after release, the first valid beat starts a new vector with cnt=1.
- Basic dot product:
  - Stimulus: I_BITS=8, i_len=4, a={1,2,3,4}, b={5,6,7,8} on 4 consecutive valid beats, i_c_ready=1.
  - Required: o_c=70 and o_c_valid=1 one cycle after beat 4; o_a/o_b echo each beat 1 cycle later.
- Bubbles and signs: i_len=3, beats (-128,-128),(127,-128),(-1,1) with 2 idle cycles between beats -> o_c=16384-16256-1=127.
- Back-to-back with different lengths: i_len=2 {(2,3),(4,5)}, then i_len=1 {(-7,6)}, no gaps, i_c_ready=1 -> results 26 then -42 on consecutive emit cycles; i_len=0 behaves as length 1.
- Backpressure: i_c_ready=0 across two emits -> o_c holds the second value and o_overrun=1 until i_clear; emit coinciding with a consume -> o_c_valid stays 1 and o_overrun stays 0.
- PE_QOUT_EN with I_BITS=8:
  - o_c=16384 (1.0*1.0) -> o_q=127 (saturated).
  - o_c=64 -> o_q=1 (rounded up from 0.5).
  - o_c=-16512 -> o_q=-128.

Source files
------------

// File: rtl/pe_mac_stream_pkg.sv
// Shared definitions for the pe_mac_stream processing element:
// FSM state encoding, default sizes and the width derivation helpers.
package pe_pkg;

    localparam int DEF_I_BITS  = 8;
    localparam int DEF_MAX_LEN = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pe_state_e;

    // Full-resolution result width: product width plus growth for MAX_LEN terms.
    function automatic int calc_o_bits(input int i_bits, input int max_len);
        return 2 * i_bits + $clog2(max_len);
    endfunction

    // Width able to hold any length from 0 to MAX_LEN inclusive.
    function automatic int calc_len_bits(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pe_mac_stream_if.sv
// Operand stream, neighbour forwarding and result handshake of one PE.
// The slave modport is the PE itself; the master modport is its environment.
interface pe_mac_stream_if
    import pe_pkg::*;
#(
    parameter int I_BITS  = DEF_I_BITS,
    parameter int MAX_LEN = DEF_MAX_LEN
) ();

    localparam int LEN_BITS = calc_len_bits(MAX_LEN);
    localparam int O_BITS   = calc_o_bits(I_BITS, MAX_LEN);

    logic                i_valid;
    logic [I_BITS-1:0]   i_a;
    logic [I_BITS-1:0]   i_b;
    logic [LEN_BITS-1:0] i_len;
    logic [I_BITS-1:0]   o_a;
    logic [I_BITS-1:0]   o_b;
    logic                o_valid;
    logic [O_BITS-1:0]   o_c;
    logic                o_c_valid;
    logic                i_c_ready;
    logic                o_busy;
    logic                o_overrun;
    logic [I_BITS-1:0]   o_q;

    modport slave (
        input  i_valid, i_a, i_b, i_len, i_c_ready,
        output o_a, o_b, o_valid, o_c, o_c_valid, o_busy, o_overrun, o_q
    );

    modport master (
        output i_valid, i_a, i_b, i_len, i_c_ready,
        input  o_a, o_b, o_valid, o_c, o_c_valid, o_busy, o_overrun, o_q
    );

endinterface

// File: rtl/pe_mac_stream_quant_sat.sv
// pe_quant_sat: combinational round-half-up and saturate of a full-resolution
// S(O_BITS, 2*I_BITS-2) value down to S(I_BITS, I_BITS-1).
module pe_quant_sat #(
    parameter int I_BITS = 8,
    parameter int O_BITS = 20
) (
    input  logic signed [O_BITS-1:0] i_c,
    output logic        [I_BITS-1:0] o_q
);

    // One guard bit so the rounding add can never wrap.
    localparam logic signed [O_BITS:0] HALF  = (O_BITS+1)'(64'sd1 <<< (I_BITS - 2));
    localparam logic signed [O_BITS:0] Q_MAX = (O_BITS+1)'((64'sd1 <<< (I_BITS - 1)) - 64'sd1);
    localparam logic signed [O_BITS:0] Q_MIN = (O_BITS+1)'(-(64'sd1 <<< (I_BITS - 1)));

    logic signed [O_BITS:0] w_rnd;
    logic signed [O_BITS:0] w_shr;

    assign w_rnd = $signed({i_c[O_BITS-1], i_c}) + HALF;
    assign w_shr = w_rnd >>> (I_BITS - 1);

    // Clamp the rounded value into the narrow signed range.
    always_comb begin
        o_q = w_shr[I_BITS-1:0];
        if (w_shr > Q_MAX) begin
            o_q = Q_MAX[I_BITS-1:0];
        end else if (w_shr < Q_MIN) begin
            o_q = Q_MIN[I_BITS-1:0];
        end else begin
            o_q = w_shr[I_BITS-1:0];
        end
    end

endmodule

// File: rtl/pe_mac_stream.sv
// pe_mac_stream: systolic PE. Forwards operands right/down with one cycle of
// latency, accumulates a runtime-programmable number of signed products and
// parks each result in a valid/ready holding slot.
// Optional feature macro: PE_QOUT_EN (quantised o_q output).
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int I_BITS  = DEF_I_BITS,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_clear,
    pe_mac_stream_if.slave  bus
);

    localparam int LEN_BITS = calc_len_bits(MAX_LEN);
    localparam int O_BITS   = calc_o_bits(I_BITS, MAX_LEN);

    logic signed [I_BITS-1:0]   w_a;
    logic signed [I_BITS-1:0]   w_b;
    logic signed [2*I_BITS-1:0] w_prod;
    logic signed [O_BITS-1:0]   w_prod_ext;
    logic signed [O_BITS-1:0]   w_sum;
    logic [LEN_BITS-1:0]        w_len_eff;
    logic [LEN_BITS-1:0]        w_cnt_next;
    logic                       w_emit;

    logic [I_BITS-1:0]          r_a;
    logic [I_BITS-1:0]          r_b;
    logic                       r_valid;
    pe_state_e                  r_state;
    logic signed [O_BITS-1:0]   r_acc;
    logic [LEN_BITS-1:0]        r_cnt;
    logic [LEN_BITS-1:0]        r_len_q;
    logic [O_BITS-1:0]          r_c;
    logic                       r_c_valid;
    logic                       r_overrun;

    assign w_a        = bus.i_a;
    assign w_b        = bus.i_b;
    assign w_prod     = w_a * w_b;
    assign w_prod_ext = {{(O_BITS - 2*I_BITS){w_prod[2*I_BITS-1]}}, w_prod};
    assign w_cnt_next = r_cnt + LEN_BITS'(1);

    // Length clamp: zero means one term, anything above MAX_LEN is capped.
    always_comb begin
        w_len_eff = bus.i_len;
        if (bus.i_len == LEN_BITS'(0)) begin
            w_len_eff = LEN_BITS'(1);
        end else if (bus.i_len > LEN_BITS'(MAX_LEN)) begin
            w_len_eff = LEN_BITS'(MAX_LEN);
        end else begin
            w_len_eff = bus.i_len;
        end
    end

    // Final-sum selection and emit detection for the current beat.
    always_comb begin
        w_emit = 1'b0;
        w_sum  = w_prod_ext;
        case (r_state)
            IDLE: begin
                w_sum  = w_prod_ext;
                w_emit = bus.i_valid && !i_clear && (w_len_eff == LEN_BITS'(1));
            end
            RUN: begin
                w_sum  = r_acc + w_prod_ext;
                w_emit = bus.i_valid && !i_clear && (w_cnt_next == r_len_q);
            end
            default: begin
                w_sum  = w_prod_ext;
                w_emit = 1'b0;
            end
        endcase
    end

    // Neighbour forwarding: unconditional one-cycle pipeline, immune to clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_valid <= bus.i_valid;
        end
    end

    // Accumulator FSM: first beat latches length, last beat returns to IDLE.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
        end else if (i_clear) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_valid) begin
                        r_len_q <= w_len_eff;
                        r_acc   <= w_prod_ext;
                        if (w_len_eff == LEN_BITS'(1)) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= LEN_BITS'(1);
                            r_state <= RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.i_valid) begin
                        r_acc <= w_sum;
                        if (w_cnt_next == r_len_q) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_state <= RUN;
                        end
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Result slot: emit loads (flagging overrun if unconsumed), ready drains.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_c       <= '0;
            r_c_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            r_c       <= '0;
            r_c_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_emit) begin
            r_c       <= w_sum;
            r_c_valid <= 1'b1;
            if (r_c_valid && !bus.i_c_ready) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end else if (r_c_valid && bus.i_c_ready) begin
            r_c_valid <= 1'b0;
        end else begin
            r_c_valid <= r_c_valid;
        end
    end

`ifdef PE_QOUT_EN
    logic [I_BITS-1:0] w_q;
    logic [I_BITS-1:0] r_q;

    pe_quant_sat #(
        .I_BITS (I_BITS),
        .O_BITS (O_BITS)
    ) u_quant (
        .i_c (w_sum),
        .o_q (w_q)
    );

    // Quantised copy of the slot, loaded on the same edge as o_c.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (w_emit) begin
            r_q <= w_q;
        end else begin
            r_q <= r_q;
        end
    end

    assign bus.o_q = r_q;
`else
    assign bus.o_q = '0;
`endif

    assign bus.o_a       = r_a;
    assign bus.o_b       = r_b;
    assign bus.o_valid   = r_valid;
    assign bus.o_c       = r_c;
    assign bus.o_c_valid = r_c_valid;
    assign bus.o_busy    = (r_state == RUN);
    assign bus.o_overrun = r_overrun;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Self-checking bench for pe_mac_stream: directed vector table, async reset
// sequence and randomized traffic against a queue-based reference model.
module tb_pe_mac_stream;

    localparam int I_BITS  = 8;
    localparam int MAX_LEN = 16;

    logic clk;
    logic rst_n;
    logic clear;

    int checks   = 0;
    int failures = 0;

    pe_mac_stream_if #(.I_BITS(I_BITS), .MAX_LEN(MAX_LEN)) bus ();

    pe_mac_stream #(.I_BITS(I_BITS), .MAX_LEN(MAX_LEN)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_clear   (clear),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending products of the open vector and the slot.
    longint m_prods[$];
    int     m_len;
    longint m_c;
    bit     m_cv;
    bit     m_ov;
    longint m_q;
    longint m_a;
    longint m_b;
    bit     m_v;

    typedef struct {
        bit     v;
        int     a;
        int     b;
        int     len;
        bit     rdy;
        bit     clr;
        longint c;
        bit     cv;
        bit     ov;
        bit     chkq;
        longint q;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint quant(input longint c);
        longint r;
        r = (c + (64'sd1 <<< (I_BITS - 2))) >>> (I_BITS - 1);
        if (r > 127) return 127;
        if (r < -128) return -128;
        return r;
    endfunction

    function automatic int eff_len(input int len);
        if (len == 0) return 1;
        if (len > MAX_LEN) return MAX_LEN;
        return len;
    endfunction

    function automatic longint q_exp();
`ifdef PE_QOUT_EN
        return m_q;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_prods.delete();
        m_len = 0;
        m_c = 0; m_cv = 0; m_ov = 0; m_q = 0;
        m_a = 0; m_b = 0; m_v = 0;
    endtask

    // Apply one beat, advance the model at the edge, then compare all outputs.
    task automatic do_cycle(input bit v, input int a, input int b, input int len,
                            input bit rdy, input bit clr);
        bit     emit;
        longint sum;
        bus.i_valid   = v;
        bus.i_a       = I_BITS'(a);
        bus.i_b       = I_BITS'(b);
        bus.i_len     = 5'(len);
        bus.i_c_ready = rdy;
        clear         = clr;
        @(posedge clk);
        m_a = longint'(a);
        m_b = longint'(b);
        m_v = v;
        emit = 0;
        sum  = 0;
        if (clr) begin
            m_prods.delete();
            m_len = 0;
            m_c = 0; m_cv = 0; m_ov = 0; m_q = 0;
        end else begin
            if (v) begin
                if (m_prods.size() == 0) m_len = eff_len(len);
                m_prods.push_back(longint'(a) * longint'(b));
                if (m_prods.size() == m_len) begin
                    emit = 1;
                    foreach (m_prods[i]) sum += m_prods[i];
                    m_prods.delete();
                end
            end
            if (emit) begin
                if (m_cv && !rdy) m_ov = 1;
                m_c  = sum;
                m_cv = 1;
                m_q  = quant(sum);
            end else if (m_cv && rdy) begin
                m_cv = 0;
            end
        end
        #1;
        chk("o_a",       longint'($signed(bus.o_a)), m_a);
        chk("o_b",       longint'($signed(bus.o_b)), m_b);
        chk("o_valid",   longint'(bus.o_valid), longint'(m_v));
        chk("o_c",       longint'($signed(bus.o_c)), m_c);
        chk("o_c_valid", longint'(bus.o_c_valid), longint'(m_cv));
        chk("o_busy",    longint'(bus.o_busy), longint'(m_prods.size() != 0));
        chk("o_overrun", longint'(bus.o_overrun), longint'(m_ov));
        chk("o_q",       longint'($signed(bus.o_q)), q_exp());
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_o_a"},       longint'(bus.o_a), 0);
        chk({tag, "_o_b"},       longint'(bus.o_b), 0);
        chk({tag, "_o_valid"},   longint'(bus.o_valid), 0);
        chk({tag, "_o_c"},       longint'(bus.o_c), 0);
        chk({tag, "_o_c_valid"}, longint'(bus.o_c_valid), 0);
        chk({tag, "_o_busy"},    longint'(bus.o_busy), 0);
        chk({tag, "_o_overrun"}, longint'(bus.o_overrun), 0);
        chk({tag, "_o_q"},       longint'(bus.o_q), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0;
        bus.i_len = '0;     bus.i_c_ready = 1'b0;
        model_reset();

        //                v  a     b     len rdy clr  c       cv ov chkq q
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b1,      0, 1'b0, 1'b0, 1'b0,    0});
        // basic dot product 1*5+2*6+3*7+4*8
        tbl.push_back('{1'b1,    1,    5, 4, 1'b1, 1'b0,      0, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    2,    6, 4, 1'b1, 1'b0,      0, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    3,    7, 4, 1'b1, 1'b0,      0, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    4,    8, 4, 1'b1, 1'b0,     70, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,     70, 1'b0, 1'b0, 1'b0,    0});
        // bubbles and signs
        tbl.push_back('{1'b1, -128, -128, 3, 1'b1, 1'b0,     70, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,     70, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,     70, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,  127, -128, 0, 1'b1, 1'b0,     70, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,     70, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,     70, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,   -1,    1, 0, 1'b1, 1'b0,    127, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,    127, 1'b0, 1'b0, 1'b0,    0});
        // back-to-back: len2, len1, len0
        tbl.push_back('{1'b1,    2,    3, 2, 1'b1, 1'b0,    127, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    4,    5, 2, 1'b1, 1'b0,     26, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,   -7,    6, 1, 1'b1, 1'b0,    -42, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    3,    3, 0, 1'b1, 1'b0,      9, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,      9, 1'b0, 1'b0, 1'b0,    0});
        // backpressure: two emits without ready
        tbl.push_back('{1'b1,    2,    2, 1, 1'b0, 1'b0,      4, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    3,   -2, 1, 1'b0, 1'b0,     -6, 1'b1, 1'b1, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b0, 1'b0,     -6, 1'b1, 1'b1, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,     -6, 1'b0, 1'b1, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b1,      0, 1'b0, 1'b0, 1'b0,    0});
        // emit coinciding with consume, then clear discarding a beat
        tbl.push_back('{1'b1,    5,    5, 1, 1'b1, 1'b0,     25, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    1,    1, 1, 1'b1, 1'b0,      1, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b0, 1'b0,      1, 1'b1, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b1,    9,    9, 1, 1'b1, 1'b1,      0, 1'b0, 1'b0, 1'b0,    0});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0,      0, 1'b0, 1'b0, 1'b0,    0});
        // quantisation corners
        tbl.push_back('{1'b1, -128, -128, 1, 1'b1, 1'b0,  16384, 1'b1, 1'b0, 1'b1,  127});
        tbl.push_back('{1'b1,    8,    8, 1, 1'b1, 1'b0,     64, 1'b1, 1'b0, 1'b1,    1});
        tbl.push_back('{1'b1, -128,  127, 2, 1'b1, 1'b0,     64, 1'b0, 1'b0, 1'b1,    1});
        tbl.push_back('{1'b1, -128,    2, 2, 1'b1, 1'b0, -16512, 1'b1, 1'b0, 1'b1, -128});
        tbl.push_back('{1'b0,    0,    0, 0, 1'b1, 1'b0, -16512, 1'b0, 1'b0, 1'b1, -128});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        foreach (tbl[i]) begin
            do_cycle(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].len, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_c", i),  longint'($signed(bus.o_c)), tbl[i].c);
            chk($sformatf("tbl%0d_cv", i), longint'(bus.o_c_valid), longint'(tbl[i].cv));
            chk($sformatf("tbl%0d_ov", i), longint'(bus.o_overrun), longint'(tbl[i].ov));
`ifdef PE_QOUT_EN
            if (tbl[i].chkq) chk($sformatf("tbl%0d_q", i), longint'($signed(bus.o_q)), tbl[i].q);
`endif
        end

        // Async reset in the middle of a vector
        do_cycle(1'b1, 1, 1, 1, 1'b0, 1'b0);
        do_cycle(1'b1, 2, 3, 4, 1'b0, 1'b0);
        do_cycle(1'b1, 2, 3, 4, 1'b0, 1'b0);
        chk("pre_rst_busy", longint'(bus.o_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b1, 3, 4, 2, 1'b1, 1'b0);
        chk("post_rst_busy", longint'(bus.o_busy), 1);
        do_cycle(1'b1, 5, 6, 2, 1'b1, 1'b0);
        chk("post_rst_c", longint'($signed(bus.o_c)), 42);
        chk("post_rst_cv", longint'(bus.o_c_valid), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            do_cycle(($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 20)),
                     ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 60) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
